// File: rtl/uart_rx_oversampled.sv
// uart_rx_oversampled: 8N1-style serial receiver driven by a 16x oversampling tick.
// Recovers start/data/stop framing from an asynchronous rx line. It presents each
// good byte with a one-cycle data_valid strobe and flags a bad stop bit with a
// one-cycle frame_err strobe. A line held low after a framing error is parked
// in BREAK, so the held-low line cannot produce repeated frames.
module uart_rx_oversampled #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 baud_en,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int BIT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [3:0] TICK_MID = 4'(OVERSAMPLE / 2 - 1);
    localparam logic [3:0] TICK_LAST = 4'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_BREAK
    } state_t;

    state_t               state, state_nxt;
    logic [3:0]           tick_cnt, tick_nxt;
    logic [BIT_W-1:0]     bit_cnt, bit_nxt;
    logic [DATA_BITS-1:0] shift_reg, shift_nxt;
    logic                 load_data;
    logic                 valid_nxt;
    logic                 err_nxt;
    logic                 rx_meta;
    logic                 rx_sync;

    // Two-flop synchronizer for the asynchronous line; resets to idle-high.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
        end
    end

    // Next-state and counter logic; nothing moves except on a baud_en tick.
    always_comb begin
        state_nxt = state;
        tick_nxt  = tick_cnt;
        bit_nxt   = bit_cnt;
        shift_nxt = shift_reg;
        load_data = 1'b0;
        valid_nxt = 1'b0;
        err_nxt   = 1'b0;
        if (baud_en) begin
            case (state)
                ST_IDLE: begin
                    if (!rx_sync) begin
                        state_nxt = ST_START;
                        tick_nxt  = 4'd0;
                        bit_nxt   = '0;
                    end
                end
                ST_START: begin
                    if (tick_cnt == TICK_MID) begin
                        // Line back high at mid start bit means a glitch, not a frame.
                        state_nxt = rx_sync ? ST_IDLE : ST_DATA;
                        tick_nxt  = 4'd0;
                        bit_nxt   = '0;
                    end else begin
                        tick_nxt = tick_cnt + 4'd1;
                    end
                end
                ST_DATA: begin
                    tick_nxt = tick_cnt + 4'd1;
                    if (tick_cnt == TICK_LAST) begin
                        // Shift right so the first (LSB) bit lands at bit 0.
                        shift_nxt = DATA_BITS'({rx_sync, shift_reg} >> 1);
                        if (bit_cnt == BIT_LAST) begin
                            state_nxt = ST_STOP;
                            tick_nxt  = 4'd0;
                            bit_nxt   = '0;
                        end else begin
                            bit_nxt = bit_cnt + BIT_W'(1);
                        end
                    end
                end
                ST_STOP: begin
                    tick_nxt = tick_cnt + 4'd1;
                    if (tick_cnt == TICK_LAST) begin
                        // Leaving at mid stop bit lets a back-to-back start edge be caught.
                        tick_nxt = 4'd0;
                        bit_nxt  = '0;
                        if (rx_sync) begin
                            load_data = 1'b1;
                            valid_nxt = 1'b1;
                            state_nxt = ST_IDLE;
                        end else begin
                            err_nxt   = 1'b1;
                            state_nxt = ST_BREAK;
                        end
                    end
                end
                ST_BREAK: begin
                    if (rx_sync) begin
                        state_nxt = ST_IDLE;
                        tick_nxt  = 4'd0;
                        bit_nxt   = '0;
                    end
                end
                default: begin
                    state_nxt = ST_IDLE;
                    tick_nxt  = 4'd0;
                    bit_nxt   = '0;
                end
            endcase
        end
    end

    // State, counters, shift register and output strobes; reset wins over baud_en.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            tick_cnt   <= 4'd0;
            bit_cnt    <= '0;
            shift_reg  <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            state      <= state_nxt;
            tick_cnt   <= tick_nxt;
            bit_cnt    <= bit_nxt;
            shift_reg  <= shift_nxt;
            data_valid <= valid_nxt;
            frame_err  <= err_nxt;
            if (load_data) begin
                data_out <= shift_reg;
            end
        end
    end

    assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// Testbench for uart_rx_oversampled: directed and random 8N1 frames checked against
// a frame-level expectation model (queue of expected bytes plus error count).
module tb_uart_rx_oversampled;

    localparam int TICK_DIV = 11;
    localparam int BIT = 16 * TICK_DIV;

    logic       clk = 1'b0;
    logic       rst;
    logic       baud_en;
    logic       rx;
    logic [7:0] data_out;
    logic       data_valid;
    logic       frame_err;
    logic       busy;

    int total = 0;
    int bad = 0;

    logic [7:0] got_q[$];
    int         err_seen = 0;
    int         overlap = 0;

    logic [7:0] exp_q[$];
    int         exp_err = 0;
    logic [7:0] last_good = 8'h00;
    int         chk_idx = 0;

    uart_rx_oversampled #(.DATA_BITS(8), .OVERSAMPLE(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .baud_en   (baud_en),
        .rx        (rx),
        .data_out  (data_out),
        .data_valid(data_valid),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Oversampling tick: one clk high every TICK_DIV clks.
    initial begin
        baud_en = 1'b0;
        forever begin
            repeat (TICK_DIV - 1) @(negedge clk);
            baud_en = 1'b1;
            @(negedge clk);
            baud_en = 1'b0;
        end
    end

    // Record every strobe cycle seen on the outputs.
    always @(negedge clk) begin
        if (data_valid === 1'b1) got_q.push_back(data_out);
        if (frame_err === 1'b1) err_seen++;
        if (data_valid === 1'b1 && frame_err === 1'b1) overlap++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Expected effect of one complete frame on the receiver's outputs.
    task automatic model_frame(input logic [7:0] b, input logic stop_bit);
        if (stop_bit) begin
            exp_q.push_back(b);
            last_good = b;
        end else begin
            exp_err++;
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int gap_bits);
        rx = 1'b0;
        wait_clk(BIT);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            wait_clk(BIT);
        end
        rx = stop_bit;
        wait_clk(BIT);
        rx = 1'b1;
        wait_clk(gap_bits * BIT);
    endtask

    task automatic check_all(input string tag);
        int n;
        chk({tag, ".valid_count"}, got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = chk_idx; i < n; i++) begin
            chk($sformatf("%s.byte%0d", tag, i), got_q[i], exp_q[i]);
        end
        chk_idx = n;
        chk({tag, ".err_count"}, err_seen, exp_err);
        chk({tag, ".data_out"}, data_out, last_good);
        chk({tag, ".overlap"}, overlap, 0);
    endtask

    initial begin
        logic [7:0] b;
        logic       sb;
        int         gap;

        // Reset state
        rst = 1'b1;
        rx  = 1'b1;
        wait_clk(5);
        chk("reset.data_out", data_out, 8'h00);
        chk("reset.data_valid", data_valid, 1'b0);
        chk("reset.frame_err", frame_err, 1'b0);
        chk("reset.busy", busy, 1'b0);
        rst = 1'b0;
        wait_clk(2 * BIT);

        // Normal frame
        model_frame(8'hA5, 1'b1);
        send_frame(8'hA5, 1'b1, 1);
        check_all("normal");
        chk("normal.busy_after", busy, 1'b0);

        // Back-to-back frames with no idle gap
        model_frame(8'h00, 1'b1);
        send_frame(8'h00, 1'b1, 0);
        model_frame(8'hFF, 1'b1);
        send_frame(8'hFF, 1'b1, 1);
        check_all("b2b");

        // Start glitch: 3 ticks low, then high
        rx = 1'b0;
        wait_clk(TICK_DIV + TICK_DIV / 2 + 4);
        chk("glitch.busy_during", busy, 1'b1);
        wait_clk(3 * TICK_DIV - (TICK_DIV + TICK_DIV / 2 + 4));
        rx = 1'b1;
        wait_clk(12 * TICK_DIV);
        chk("glitch.busy_after", busy, 1'b0);
        check_all("glitch");

        // Framing error followed by a long break
        model_frame(8'h3C, 1'b0);
        send_frame(8'h3C, 1'b0, 0);
        rx = 1'b0;
        wait_clk(20 * BIT);
        check_all("break");
        chk("break.busy_held", busy, 1'b1);
        rx = 1'b1;
        wait_clk(BIT);
        chk("break.busy_released", busy, 1'b0);
        model_frame(8'h81, 1'b1);
        send_frame(8'h81, 1'b1, 1);
        check_all("after_break");

        // Reset in the middle of data bit 4 of 0x77
        b  = 8'h77;
        rx = 1'b0;
        wait_clk(BIT);
        for (int i = 0; i < 4; i++) begin
            rx = b[i];
            wait_clk(BIT);
        end
        rx = b[4];
        wait_clk(BIT / 2);
        chk("midrst.busy_before", busy, 1'b1);
        rst = 1'b1;
        wait_clk(1);
        last_good = 8'h00;
        chk("midrst.busy", busy, 1'b0);
        chk("midrst.data_valid", data_valid, 1'b0);
        rst = 1'b0;
        rx  = 1'b1;
        wait_clk(2 * BIT);
        check_all("midrst");
        model_frame(8'h5A, 1'b1);
        send_frame(8'h5A, 1'b1, 1);
        check_all("after_midrst");

        // Reset precedence over baud_en and a low rx line
        rst = 1'b1;
        rx  = 1'b0;
        for (int i = 0; i < 4 * TICK_DIV; i++) begin
            wait_clk(1);
            chk("rst_hold.outputs", {data_out, data_valid, frame_err, busy}, 32'h0);
        end
        last_good = 8'h00;
        rx = 1'b1;
        wait_clk(4);
        rst = 1'b0;
        wait_clk(BIT);
        check_all("rst_hold");

        // Random frames: random data, mostly good stop bits, random idle gaps
        for (int k = 0; k < 6; k++) begin
            b   = 8'($urandom_range(0, 255));
            sb  = ($urandom_range(0, 3) != 0);
            gap = sb ? $urandom_range(0, 2) : $urandom_range(1, 2);
            model_frame(b, sb);
            send_frame(b, sb, gap);
        end
        wait_clk(BIT);
        check_all("random");
        chk("random.busy_after", busy, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
